// File: rtl/comparer_multi_if.sv
// Byte stream in and per-channel match results out for the signature comparer.
// The comparer connects through the slave modport. The byte receiver and the
// dispatcher side connect through the master modport.
interface comparer_multi_if #(
  parameter int B = 8,
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          restart;
  logic          load;
  logic [B-1:0]  data;
  logic [N-1:0]  resolve;
  logic [N-1:0]  reject;
  logic          match_valid;
  logic [IW-1:0] match_index;
  logic          none_alive;

  modport master (
    output restart, load, data,
    input  resolve, reject, match_valid, match_index, none_alive
  );

  modport slave (
    input  restart, load, data,
    output resolve, reject, match_valid, match_index, none_alive
  );
endinterface

// File: rtl/comparer_multi.sv
// Multi-channel streaming signature comparer for the NMEA receive path.
// Each received byte is compared against N reference strings at the same time.
// Per-channel resolve and reject pulses are registered one cycle after the load.
// The first resolving channel is held as a sticky index.
//
// state        | meaning
// ST_MATCHING  | channel is comparing; cnt is the next reference byte to check
// ST_DONE      | anchored mode only: full match seen, idle until restart
// ST_DEAD      | anchored mode only: mismatch seen, idle until restart
module comparer_multi #(
  parameter int              B           = 8,
  parameter int              L           = 6,
  parameter int              N           = 4,
  parameter logic [N*L*B-1:0] REFS       = {"$GPGSV", "$GPGGA", "$GPRMC", "$GPZDA"},
  parameter logic [B-1:0]    WILDCARD    = 8'h3F,
  parameter bit              WILDCARD_EN = 1'b1,
  parameter int              MODE        = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  comparer_multi_if.slave  bus
);
  localparam int CW = $clog2(L + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_MATCHING = 2'd0,
    ST_DONE     = 2'd1,
    ST_DEAD     = 2'd2
  } ch_state_e;

  ch_state_e     state_q [N];
  ch_state_e     state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  resolve_q, resolve_d;
  logic [N-1:0]  reject_q, reject_d;
  logic          match_valid_q, match_valid_d;
  logic [IW-1:0] match_index_q, match_index_d;
  logic          none_alive_q, none_alive_d;

  // Per-channel compare and next state. A restart overrides the stored state for this cycle's compare.
  always_comb begin
    logic [CW-1:0] cnt_eff;
    ch_state_e     st_eff;
    logic [B-1:0]  ref_b;
    logic [B-1:0]  ref0;
    logic          hit;
    logic          hit0;
    resolve_d = '0;
    reject_d  = '0;
    cnt_eff   = '0;
    st_eff    = ST_MATCHING;
    ref_b     = '0;
    ref0      = '0;
    hit       = 1'b0;
    hit0      = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt_eff    = bus.restart ? '0 : cnt_q[i];
      st_eff     = bus.restart ? ST_MATCHING : state_q[i];
      cnt_d[i]   = cnt_eff;
      state_d[i] = st_eff;
      // The first reference byte sits in the most significant position of the channel slice.
      ref_b = REFS[(i*L + (L - 1 - int'(cnt_eff)))*B +: B];
      ref0  = REFS[(i*L + (L - 1))*B +: B];
      hit   = (bus.data == ref_b) || (WILDCARD_EN && (ref_b == WILDCARD));
      hit0  = (bus.data == ref0)  || (WILDCARD_EN && (ref0 == WILDCARD));
      if (bus.load && (st_eff == ST_MATCHING)) begin
        if (hit) begin
          if (cnt_eff == CW'(L - 1)) begin
            resolve_d[i] = 1'b1;
            if (MODE == 1) cnt_d[i] = '0;
            else           state_d[i] = ST_DONE;
          end else begin
            cnt_d[i] = cnt_eff + 1'b1;
          end
        end else begin
          reject_d[i] = 1'b1;
          // In search mode a mismatching byte may itself be the start of a new match.
          if (MODE == 1) cnt_d[i] = (hit0 && (L > 1)) ? CW'(1) : '0;
          else           state_d[i] = ST_DEAD;
        end
      end
    end
  end

  // Sticky first-match capture and the all-dead flag. Both are cleared by restart in the same edge.
  always_comb begin
    match_valid_d = bus.restart ? 1'b0 : match_valid_q;
    match_index_d = bus.restart ? '0 : match_index_q;
    if (!match_valid_d && (resolve_d != '0)) begin
      match_valid_d = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (resolve_d[i]) match_index_d = IW'(i);
      end
    end
    none_alive_d = (MODE == 0);
    for (int i = 0; i < N; i++) begin
      if (state_d[i] != ST_DEAD) none_alive_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_MATCHING;
        cnt_q[i]   <= '0;
      end
      resolve_q     <= '0;
      reject_q      <= '0;
      match_valid_q <= 1'b0;
      match_index_q <= '0;
      none_alive_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      resolve_q     <= resolve_d;
      reject_q      <= reject_d;
      match_valid_q <= match_valid_d;
      match_index_q <= match_index_d;
      none_alive_q  <= none_alive_d;
    end
  end

  assign bus.resolve     = resolve_q;
  assign bus.reject      = reject_q;
  assign bus.match_valid = match_valid_q;
  assign bus.match_index = match_index_q;
  assign bus.none_alive  = none_alive_q;

endmodule
